// File: rtl/noc_packet_sink_pkg.sv
// Shared NoC definitions for the packet sink: flit field map, marker codes,
// error-bit indices and the receiver FSM state encoding.
// Flit layout, MSB first: {H marker, src X, src Y, dst X, dst Y, TYPE, PACK_ORDER, LEN, E marker, pad}.
package noc_packet_sink_pkg;

  localparam int NOC_DATA_WIDTH = 64;
  localparam int NOC_ID_X_WIDTH = 4;
  localparam int NOC_ID_Y_WIDTH = 4;
  localparam int AXI_LEN_BIT    = 8;
  localparam int NOC_MARK_WIDTH = 4;
  localparam int NOC_TYPE_WIDTH = 2;
  localparam int NOC_ORD_WIDTH  = 2;
  localparam int NOC_PAD_WIDTH  = NOC_DATA_WIDTH - 2 * NOC_MARK_WIDTH
                                  - 2 * NOC_ID_X_WIDTH - 2 * NOC_ID_Y_WIDTH
                                  - NOC_TYPE_WIDTH - NOC_ORD_WIDTH - AXI_LEN_BIT;

  // Framing markers carried in the H and E marker fields.
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_HEAD_H = 4'hA;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_HEAD_E = 4'h5;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_TAIL_H = 4'hC;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_TAIL_E = 4'h3;

  // Bit positions inside pkt_err.
  localparam int ERR_UNTERM   = 0;
  localparam int ERR_MARKER   = 1;
  localparam int ERR_MISROUTE = 2;
  localparam int ERR_LEN      = 3;
  localparam int ERR_TIMEOUT  = 4;
  localparam int ERR_W        = 5;

  // Field map of a header (and, for the marker fields, of a tail) flit.
  typedef struct packed {
    logic [NOC_MARK_WIDTH-1:0] h_mark;
    logic [NOC_ID_X_WIDTH-1:0] src_x;
    logic [NOC_ID_Y_WIDTH-1:0] src_y;
    logic [NOC_ID_X_WIDTH-1:0] dst_x;
    logic [NOC_ID_Y_WIDTH-1:0] dst_y;
    logic [NOC_TYPE_WIDTH-1:0] typ;
    logic [NOC_ORD_WIDTH-1:0]  pack_order;
    logic [AXI_LEN_BIT-1:0]    len;
    logic [NOC_MARK_WIDTH-1:0] e_mark;
    logic [NOC_PAD_WIDTH-1:0]  pad;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BODY   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/noc_flit_decode.sv
// Purpose: combinational field extraction and marker / destination checks on one flit.
// Latency: zero cycles (pure combinational).
// Backpressure: none; it only observes the flit.
// Ports: flit in; src_x/src_y/len out; head_mark_ok, tail_mark_ok, dst_hit out.
module noc_flit_decode
  import noc_packet_sink_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID = '0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID = '0
) (
  input  logic [NOC_DATA_WIDTH-1:0] flit,
  output logic [NOC_ID_X_WIDTH-1:0] src_x,
  output logic [NOC_ID_Y_WIDTH-1:0] src_y,
  output logic [AXI_LEN_BIT-1:0]    len,
  output logic                      head_mark_ok,
  output logic                      tail_mark_ok,
  output logic                      dst_hit
);

  hdr_t f;
  logic unused_fields;

  assign f = hdr_t'(flit);

  assign src_x        = f.src_x;
  assign src_y        = f.src_y;
  assign len          = f.len;
  assign head_mark_ok = (f.h_mark == NOC_HEAD_H) && (f.e_mark == NOC_HEAD_E);
  assign tail_mark_ok = (f.h_mark == NOC_TAIL_H) && (f.e_mark == NOC_TAIL_E);
  assign dst_hit      = (f.dst_x == X_ID) && (f.dst_y == Y_ID);

  // TYPE, PACK_ORDER and pad are not needed by the sink.
  assign unused_fields = ^{f.typ, f.pack_order, f.pad};

endmodule

// File: rtl/noc_packet_sink.sv
// Purpose: NoC local-port receiver; checks packet framing and emits one report per packet.
// Latency: accepted tail (or second header / timeout) at cycle N gives pkt_done at N+1.
// Backpressure: ready in IDLE/BODY; ready drops for the one REPORT cycle unless a new header is already open.
// Ports: noc_clk, noc_rst_n; receive_* flit stream in; pkt_* report, orphan_err, pkt_total, err_total out.
module noc_packet_sink
  import noc_packet_sink_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID    = '0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID    = '0,
  parameter int                        CNT_W   = 8,
  parameter int                        TIMEOUT = 256
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      pkt_done,
  output logic [NOC_ID_X_WIDTH-1:0] pkt_src_x,
  output logic [NOC_ID_Y_WIDTH-1:0] pkt_src_y,
  output logic [AXI_LEN_BIT-1:0]    pkt_len,
  output logic [CNT_W-1:0]          pkt_data_cnt,
  output logic [ERR_W-1:0]          pkt_err,
  output logic                      orphan_err,
  output logic [CNT_W-1:0]          pkt_total,
  output logic [CNT_W-1:0]          err_total
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CMP_W  = (CNT_W > AXI_LEN_BIT) ? CNT_W : AXI_LEN_BIT;

  // Decoded view of the incoming flit.
  logic [NOC_ID_X_WIDTH-1:0] dec_src_x;
  logic [NOC_ID_Y_WIDTH-1:0] dec_src_y;
  logic [AXI_LEN_BIT-1:0]    dec_len;
  logic                      head_ok, tail_ok, dst_hit;

  noc_flit_decode #(.X_ID(X_ID), .Y_ID(Y_ID)) u_decode (
    .flit         (receive_flit),
    .src_x        (dec_src_x),
    .src_y        (dec_src_y),
    .len          (dec_len),
    .head_mark_ok (head_ok),
    .tail_mark_ok (tail_ok),
    .dst_hit      (dst_hit)
  );

  state_e state_q, state_d;

  // Working copy of the open packet.
  logic [NOC_ID_X_WIDTH-1:0] src_x_q, src_x_d;
  logic [NOC_ID_Y_WIDTH-1:0] src_y_q, src_y_d;
  logic [AXI_LEN_BIT-1:0]    len_q, len_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ERR_W-1:0]          err_q, err_d;
  logic [IDLE_W-1:0]         idle_q, idle_d;
  logic                      pend_q, pend_d;

  // Report registers, held until the next report.
  logic [NOC_ID_X_WIDTH-1:0] rpt_src_x_q, rpt_src_x_d;
  logic [NOC_ID_Y_WIDTH-1:0] rpt_src_y_q, rpt_src_y_d;
  logic [AXI_LEN_BIT-1:0]    rpt_len_q, rpt_len_d;
  logic [CNT_W-1:0]          rpt_cnt_q, rpt_cnt_d;
  logic [ERR_W-1:0]          rpt_err_q, rpt_err_d;
  logic                      orphan_q, orphan_d;
  logic [CNT_W-1:0]          pkt_total_q, pkt_total_d;
  logic [CNT_W-1:0]          err_total_q, err_total_d;

  logic              acc, hdr_acc, tail_acc, data_acc;
  logic              body_active, timeout_hit, rpt_fire;
  logic [IDLE_W-1:0] idle_inc;
  logic [ERR_W-1:0]  rpt_flags;

  assign acc      = receive_valid && receive_ready;
  assign hdr_acc  = acc && receive_is_header;
  // A flit flagged as both header and tail is handled as a header.
  assign tail_acc = acc && receive_is_tail && !receive_is_header;
  assign data_acc = acc && !receive_is_tail && !receive_is_header;

  // The unterminated path opens the next packet on the same edge that loads
  // the report, so the REPORT cycle then behaves as a BODY cycle for it.
  assign body_active = (state_q == ST_BODY) || ((state_q == ST_REPORT) && pend_q);

  assign idle_inc    = idle_q + IDLE_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && body_active && !acc &&
                       (idle_inc == IDLE_W'(TIMEOUT));
  assign rpt_fire    = body_active && (hdr_acc || tail_acc || timeout_hit);

  // State register.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hdr_acc) state_d = ST_BODY;
      ST_BODY:   if (rpt_fire) state_d = ST_REPORT;
      ST_REPORT: begin
        if (rpt_fire)    state_d = ST_REPORT;
        else if (pend_q) state_d = ST_BODY;
        else             state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    receive_ready = 1'b1;
    pkt_done      = 1'b0;
    if (state_q == ST_REPORT) begin
      pkt_done      = 1'b1;
      receive_ready = pend_q;
    end
  end

  // Datapath next-state.
  always_comb begin
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    idle_d      = idle_q;
    pend_d      = 1'b0;
    orphan_d    = 1'b0;
    rpt_src_x_d = rpt_src_x_q;
    rpt_src_y_d = rpt_src_y_q;
    rpt_len_d   = rpt_len_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_err_d   = rpt_err_q;
    pkt_total_d = pkt_total_q;
    err_total_d = err_total_q;
    rpt_flags   = err_q;

    if (tail_acc) begin
      rpt_flags[ERR_MARKER] = err_q[ERR_MARKER] | !tail_ok;
      rpt_flags[ERR_LEN]    = (CMP_W'(cnt_q) != CMP_W'(len_q));
    end else if (hdr_acc) begin
      rpt_flags[ERR_UNTERM] = 1'b1;
    end else if (timeout_hit) begin
      rpt_flags[ERR_TIMEOUT] = 1'b1;
    end

    // Report is loaded on entry to REPORT; totals are bumped on the same
    // edge so they already include the packet while pkt_done is high.
    if (rpt_fire) begin
      rpt_src_x_d = src_x_q;
      rpt_src_y_d = src_y_q;
      rpt_len_d   = len_q;
      rpt_cnt_d   = cnt_q;
      rpt_err_d   = rpt_flags;
      pkt_total_d = pkt_total_q + CNT_W'(1);
      if ((rpt_flags != '0) && (err_total_q != '1))
        err_total_d = err_total_q + CNT_W'(1);
    end

    if (hdr_acc && ((state_q == ST_IDLE) || body_active)) begin
      src_x_d              = dec_src_x;
      src_y_d              = dec_src_y;
      len_d                = dec_len;
      cnt_d                = '0;
      idle_d               = '0;
      err_d                = '0;
      err_d[ERR_MARKER]    = !head_ok;
      err_d[ERR_MISROUTE]  = !dst_hit;
      pend_d               = body_active;
    end else if (state_q == ST_IDLE) begin
      orphan_d = acc;
    end else if (body_active) begin
      if (data_acc) begin
        idle_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else if (!acc && !timeout_hit && (TIMEOUT != 0)) begin
        idle_d = idle_inc;
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      src_x_q     <= '0;
      src_y_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      idle_q      <= '0;
      pend_q      <= 1'b0;
      orphan_q    <= 1'b0;
      rpt_src_x_q <= '0;
      rpt_src_y_q <= '0;
      rpt_len_q   <= '0;
      rpt_cnt_q   <= '0;
      rpt_err_q   <= '0;
      pkt_total_q <= '0;
      err_total_q <= '0;
    end else begin
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
      pend_q      <= pend_d;
      orphan_q    <= orphan_d;
      rpt_src_x_q <= rpt_src_x_d;
      rpt_src_y_q <= rpt_src_y_d;
      rpt_len_q   <= rpt_len_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_err_q   <= rpt_err_d;
      pkt_total_q <= pkt_total_d;
      err_total_q <= err_total_d;
    end
  end

  assign pkt_src_x    = rpt_src_x_q;
  assign pkt_src_y    = rpt_src_y_q;
  assign pkt_len      = rpt_len_q;
  assign pkt_data_cnt = rpt_cnt_q;
  assign pkt_err      = rpt_err_q;
  assign orphan_err   = orphan_q;
  assign pkt_total    = pkt_total_q;
  assign err_total    = err_total_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
module tb_noc_packet_sink;
  import noc_packet_sink_pkg::*;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [63:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        pkt_done;
  logic [3:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [7:0]  pkt_data_cnt;
  logic [4:0]  pkt_err;
  logic        orphan_err;
  logic [7:0]  pkt_total, err_total;

  noc_packet_sink #(.X_ID(4'd1), .Y_ID(4'd2), .CNT_W(8), .TIMEOUT(16)) dut (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .pkt_done          (pkt_done),
    .pkt_src_x         (pkt_src_x),
    .pkt_src_y         (pkt_src_y),
    .pkt_len           (pkt_len),
    .pkt_data_cnt      (pkt_data_cnt),
    .pkt_err           (pkt_err),
    .orphan_err        (orphan_err),
    .pkt_total         (pkt_total),
    .err_total         (err_total)
  );

  always #5 noc_clk = ~noc_clk;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [63:0] DATA_FLIT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [3:0] hm;
    logic [3:0] sx, sy, dx, dy;
    logic [7:0] len;
    int         nd;
    logic [3:0] th, te;
    logic [4:0] exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [63:0] mk(input logic [3:0] hm, input logic [3:0] sx, input logic [3:0] sy,
                                     input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                                     input logic [3:0] em);
    return {hm, sx, sy, dx, dy, 2'b01, 2'b00, len, em, 28'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one flit and hold it until accepted (bounded); returns #1 after the accepting edge.
  task automatic send(input logic [63:0] f, input logic h, input logic t);
    int k;
    k = 0;
    receive_valid     = 1'b1;
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    while (!receive_ready && k < 20) begin
      @(posedge noc_clk); #1;
      k++;
    end
    if (!receive_ready) chk("send_ready_timeout", 64'(receive_ready), 64'd1);
    @(posedge noc_clk); #1;
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    receive_flit      = '0;
  endtask

  task automatic tick();
    @(posedge noc_clk); #1;
  endtask

  int exp_total = 0;
  int exp_errt  = 0;
  int n;
  int seen;

  initial begin
    // {hm, sx, sy, dx, dy, len, nd, tail H, tail E, expected pkt_err}
    vecs[0] = '{4'hA, 4'd0, 4'd0, 4'd1, 4'd2, 8'd1, 1, 4'hC, 4'h3, 5'b00000}; // clean
    vecs[1] = '{4'hA, 4'd3, 4'd1, 4'd2, 4'd2, 8'd1, 1, 4'hC, 4'h3, 5'b00100}; // misroute
    vecs[2] = '{4'hA, 4'd0, 4'd3, 4'd1, 4'd2, 8'd2, 1, 4'hC, 4'h3, 5'b01000}; // len mismatch
    vecs[3] = '{4'hB, 4'd2, 4'd0, 4'd1, 4'd2, 8'd1, 1, 4'hC, 4'h3, 5'b00010}; // bad head marker
    vecs[4] = '{4'hA, 4'd4, 4'd4, 4'd1, 4'd2, 8'd2, 2, 4'hC, 4'h0, 5'b00010}; // bad tail marker
    vecs[5] = '{4'hA, 4'd6, 4'd5, 4'd1, 4'd2, 8'd0, 0, 4'hC, 4'h3, 5'b00000}; // LEN 0, no data
    vecs[6] = '{4'hA, 4'd5, 4'd6, 4'd7, 4'd7, 8'd3, 1, 4'hC, 4'h3, 5'b01100}; // misroute + len

    repeat (3) @(posedge noc_clk);
    #1;
    chk("rst_ready", 64'(receive_ready), 64'd1);
    chk("rst_done", 64'(pkt_done), 64'd0);
    chk("rst_err", 64'(pkt_err), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);
    chk("rst_total", 64'(pkt_total), 64'd0);
    chk("rst_errtot", 64'(err_total), 64'd0);
    chk("rst_src", 64'({pkt_src_x, pkt_src_y, pkt_data_cnt}), 64'd0);
    noc_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      send(mk(vecs[i].hm, vecs[i].sx, vecs[i].sy, vecs[i].dx, vecs[i].dy, vecs[i].len, 4'h5), 1'b1, 1'b0);
      for (int d = 0; d < vecs[i].nd; d++) send(DATA_FLIT, 1'b0, 1'b0);
      chk($sformatf("v%0d_no_early_done", i), 64'(pkt_done), 64'd0);
      send(mk(vecs[i].th, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0, vecs[i].te), 1'b0, 1'b1);
      exp_total++;
      if (vecs[i].exp_err != 5'b0) exp_errt++;
      chk($sformatf("v%0d_done", i), 64'(pkt_done), 64'd1);
      chk($sformatf("v%0d_ready_low", i), 64'(receive_ready), 64'd0);
      chk($sformatf("v%0d_src", i), 64'({pkt_src_x, pkt_src_y}), 64'({vecs[i].sx, vecs[i].sy}));
      chk($sformatf("v%0d_len", i), 64'(pkt_len), 64'(vecs[i].len));
      chk($sformatf("v%0d_cnt", i), 64'(pkt_data_cnt), 64'(vecs[i].nd));
      chk($sformatf("v%0d_err", i), 64'(pkt_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_total", i), 64'(pkt_total), 64'(exp_total));
      chk($sformatf("v%0d_errtot", i), 64'(err_total), 64'(exp_errt));
      tick();
      chk($sformatf("v%0d_done_1cyc", i), 64'(pkt_done), 64'd0);
      chk($sformatf("v%0d_ready_back", i), 64'(receive_ready), 64'd1);
      chk($sformatf("v%0d_err_hold", i), 64'(pkt_err), 64'(vecs[i].exp_err));
    end

    // Orphan data flit in IDLE.
    send(DATA_FLIT, 1'b0, 1'b0);
    chk("orphan_pulse", 64'(orphan_err), 64'd1);
    chk("orphan_no_done", 64'(pkt_done), 64'd0);
    tick();
    chk("orphan_1cyc", 64'(orphan_err), 64'd0);
    chk("orphan_total", 64'(pkt_total), 64'(exp_total));

    // Header A, data, header B (no tail for A), data, tail.
    send(mk(4'hA, 4'd1, 4'd1, 4'd1, 4'd2, 8'd1, 4'h5), 1'b1, 1'b0);
    send(DATA_FLIT, 1'b0, 1'b0);
    send(mk(4'hA, 4'd2, 4'd3, 4'd1, 4'd2, 8'd1, 4'h5), 1'b1, 1'b0);
    exp_total++; exp_errt++;
    chk("b2b_a_done", 64'(pkt_done), 64'd1);
    chk("b2b_a_src", 64'({pkt_src_x, pkt_src_y}), 64'h11);
    chk("b2b_a_err", 64'(pkt_err), 64'b00001);
    chk("b2b_a_cnt", 64'(pkt_data_cnt), 64'd1);
    chk("b2b_a_ready", 64'(receive_ready), 64'd1);
    send(DATA_FLIT, 1'b0, 1'b0);
    chk("b2b_mid_done", 64'(pkt_done), 64'd0);
    send(mk(4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0, 4'h3), 1'b0, 1'b1);
    exp_total++;
    chk("b2b_b_done", 64'(pkt_done), 64'd1);
    chk("b2b_b_src", 64'({pkt_src_x, pkt_src_y}), 64'h23);
    chk("b2b_b_err", 64'(pkt_err), 64'b00000);
    chk("b2b_b_cnt", 64'(pkt_data_cnt), 64'd1);
    chk("b2b_total", 64'(pkt_total), 64'(exp_total));
    chk("b2b_errtot", 64'(err_total), 64'(exp_errt));
    tick();

    // Timeout: header, then no flits.
    send(mk(4'hA, 4'd3, 4'd3, 4'd1, 4'd2, 8'd1, 4'h5), 1'b1, 1'b0);
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      tick();
      n++;
      if (pkt_done) seen = 1;
    end
    exp_total++; exp_errt++;
    chk("to_seen", 64'(seen), 64'd1);
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_err", 64'(pkt_err), 64'b10000);
    chk("to_cnt", 64'(pkt_data_cnt), 64'd0);
    chk("to_total", 64'(pkt_total), 64'(exp_total));
    tick();
    chk("to_idle_ready", 64'(receive_ready), 64'd1);
    send(DATA_FLIT, 1'b0, 1'b0);
    chk("to_idle_orphan", 64'(orphan_err), 64'd1);
    tick();

    // Reset in the middle of a packet.
    send(mk(4'hA, 4'd0, 4'd1, 4'd1, 4'd2, 8'd2, 4'h5), 1'b1, 1'b0);
    send(DATA_FLIT, 1'b0, 1'b0);
    noc_rst_n = 1'b0;
    #2;
    chk("mid_rst_done", 64'(pkt_done), 64'd0);
    chk("mid_rst_ready", 64'(receive_ready), 64'd1);
    chk("mid_rst_total", 64'(pkt_total), 64'd0);
    chk("mid_rst_errtot", 64'(err_total), 64'd0);
    chk("mid_rst_rpt", 64'({pkt_err, pkt_data_cnt, pkt_src_x, pkt_src_y, pkt_len}), 64'd0);
    tick();
    noc_rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pkt_done) seen = 1;
    end
    chk("mid_rst_no_report", 64'(seen), 64'd0);
    send(mk(4'hA, 4'd0, 4'd0, 4'd1, 4'd2, 8'd1, 4'h5), 1'b1, 1'b0);
    send(DATA_FLIT, 1'b0, 1'b0);
    send(mk(4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0, 4'h3), 1'b0, 1'b1);
    chk("post_rst_done", 64'(pkt_done), 64'd1);
    chk("post_rst_err", 64'(pkt_err), 64'd0);
    chk("post_rst_total", 64'(pkt_total), 64'd1);
    chk("post_rst_errtot", 64'(err_total), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
